// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
// Iterative RV32M/RV64M multiply/divide unit. A multiply runs radix-2
// shift-add and a divide runs radix-2 restoring division, one bit per cycle,
// for XLEN cycles on unsigned magnitudes. The sign is fixed up when the result
// is written. Division by zero and signed overflow skip the iteration and go
// straight to DONE.
//
// Ports
//   clk     in   1     single clock, rising edge
//   rst     in   1     asynchronous active-high reset
//   start   in   1     begin an operation (sampled only in IDLE)
//   funct3  in   3     0 MUL 1 MULH 2 MULHSU 3 MULHU 4 DIV 5 DIVU 6 REM 7 REMU
//   op_a    in   XLEN  rs1 value
//   op_b    in   XLEN  rs2 value
//   flush   in   1     synchronous abort (wins over start)
//   busy    out  1     state is not IDLE
//   done    out  1     one-cycle pulse, result valid
//   result  out  XLEN  last completed result, held until the next DONE
// -----------------------------------------------------------------------------
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [CW-1:0]   LAST_CNT = CW'(XLEN - 1);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
  localparam logic [XLEN-1:0] ZERO     = {XLEN{1'b0}};
  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic logic [XLEN-1:0] neg_x(input logic [XLEN-1:0] v);
    return ~v + {{(XLEN-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [2*XLEN-1:0] neg_2x(input logic [2*XLEN-1:0] v);
    return ~v + {{(2*XLEN-1){1'b0}}, 1'b1};
  endfunction

  state_t            r_state;
  state_t            w_state_nxt;
  logic [2:0]        r_funct3;
  logic [XLEN-1:0]   r_hi;      // product high half / partial remainder
  logic [XLEN-1:0]   r_lo;      // multiplier bits / dividend-then-quotient bits
  logic [XLEN-1:0]   r_b_mag;   // multiplicand or divisor magnitude
  logic              r_neg;     // negate the magnitude result at the end
  logic [CW-1:0]     r_cnt;
  logic [XLEN-1:0]   r_result;

  logic              w_a_signed, w_b_signed, w_a_neg, w_b_neg, w_neg_res;
  logic [XLEN-1:0]   w_a_mag, w_b_mag;
  logic              w_div_zero, w_ovf, w_fast;
  logic [XLEN-1:0]   w_fast_res;
  logic [XLEN:0]     w_add, w_rem_sh, w_diff;
  logic [XLEN-1:0]   w_hi_nxt, w_lo_nxt, w_final;
  logic [2*XLEN-1:0] w_prod, w_prod_s;

  // Operand signedness from the requested op.
  always_comb begin
    w_a_signed = 1'b0;
    w_b_signed = 1'b0;
    case (funct3)
      3'd0, 3'd1, 3'd4, 3'd6: begin
        w_a_signed = 1'b1;
        w_b_signed = 1'b1;
      end
      3'd2: begin
        w_a_signed = 1'b1;
        w_b_signed = 1'b0;
      end
      default: begin
        w_a_signed = 1'b0;
        w_b_signed = 1'b0;
      end
    endcase
  end

  assign w_a_neg = w_a_signed & op_a[XLEN-1];
  assign w_b_neg = w_b_signed & op_b[XLEN-1];
  assign w_a_mag = w_a_neg ? neg_x(op_a) : op_a;
  assign w_b_mag = w_b_neg ? neg_x(op_b) : op_b;
  // A remainder takes the dividend's sign; everything else the XOR of signs.
  assign w_neg_res = (funct3[2] & funct3[1]) ? w_a_neg : (w_a_neg ^ w_b_neg);

  // Fast-path detection and its result (funct3[1] = remainder, funct3[0] = unsigned).
  assign w_div_zero = funct3[2] & (op_b == ZERO);
  assign w_ovf      = funct3[2] & ~funct3[0] & (op_a == MIN_NEG) & (op_b == ALL_ONES);
  assign w_fast     = w_div_zero | w_ovf;
  assign w_fast_res = w_div_zero ? (funct3[1] ? op_a : ALL_ONES)
                                 : (funct3[1] ? ZERO : op_a);

  // One radix-2 step for the latched op: shift-add or restoring subtract.
  always_comb begin
    w_add    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b_mag} : {(XLEN+1){1'b0}});
    w_rem_sh = {r_hi, r_lo[XLEN-1]};
    w_diff   = w_rem_sh - {1'b0, r_b_mag};
    if (r_funct3[2]) begin
      // Borrow out (w_diff[XLEN]) means the trial subtract failed: restore.
      if (!w_diff[XLEN]) begin
        w_hi_nxt = w_diff[XLEN-1:0];
      end else begin
        w_hi_nxt = w_rem_sh[XLEN-1:0];
      end
      w_lo_nxt = {r_lo[XLEN-2:0], ~w_diff[XLEN]};
    end else begin
      w_hi_nxt = w_add[XLEN:1];
      w_lo_nxt = {w_add[0], r_lo[XLEN-1:1]};
    end
  end

  // Sign-corrected result built from the final iteration's outputs.
  always_comb begin
    w_prod   = {w_hi_nxt, w_lo_nxt};
    w_prod_s = r_neg ? neg_2x(w_prod) : w_prod;
    if (r_funct3[2]) begin
      if (r_funct3[1]) begin
        w_final = r_neg ? neg_x(w_hi_nxt) : w_hi_nxt;
      end else begin
        w_final = r_neg ? neg_x(w_lo_nxt) : w_lo_nxt;
      end
    end else if (r_funct3[1:0] == 2'd0) begin
      w_final = w_prod_s[XLEN-1:0];
    end else begin
      w_final = w_prod_s[2*XLEN-1:XLEN];
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start && !flush) begin
          w_state_nxt = w_fast ? S_DONE : S_CALC;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_CALC: begin
        if (flush) begin
          w_state_nxt = S_IDLE;
        end else if (r_cnt == LAST_CNT) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_CALC;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from the state register.
  always_comb begin
    busy   = (r_state != S_IDLE);
    done   = (r_state == S_DONE);
    result = r_result;
  end

  // Datapath: latch operands on accept, iterate in CALC, write result on DONE entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_funct3 <= 3'd0;
      r_hi     <= ZERO;
      r_lo     <= ZERO;
      r_b_mag  <= ZERO;
      r_neg    <= 1'b0;
      r_cnt    <= {CW{1'b0}};
      r_result <= ZERO;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start && !flush) begin
            r_funct3 <= funct3;
            r_hi     <= ZERO;
            r_lo     <= w_a_mag;
            r_b_mag  <= w_b_mag;
            r_neg    <= w_neg_res;
            r_cnt    <= {CW{1'b0}};
            if (w_fast) begin
              r_result <= w_fast_res;
            end
          end
        end
        S_CALC: begin
          if (!flush) begin
            r_hi  <= w_hi_nxt;
            r_lo  <= w_lo_nxt;
            r_cnt <= r_cnt + CNT_ONE;
            if (r_cnt == LAST_CNT) begin
              r_result <= w_final;
            end
          end
        end
        default: begin
          r_hi <= r_hi;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

  localparam int XLEN = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] op_a = 32'd0;
  logic [31:0] op_b = 32'd0;
  logic        busy, done;
  logic [31:0] result;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_res = 32'd0;

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .start(start), .funct3(funct3),
    .op_a(op_a), .op_b(op_b), .flush(flush),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Behavioural reference: plain 64-bit arithmetic on the RISC-V M rules.
  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [63:0]     p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    p  = 64'd0;
    case (f)
      3'd0: begin p = ua * ub;            return p[31:0];  end
      3'd1: begin p = sa * sb;            return p[63:32]; end
      3'd2: begin p = sa * longint'(ub);  return p[63:32]; end
      3'd3: begin p = ua * ub;            return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        p = ua / ub; return p[31:0];
      end
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 32'd0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && (b == 32'd0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
      return 1;
    return XLEN + 1;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  // Called at a negedge in IDLE; returns at the negedge of the IDLE cycle after DONE.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input string tag, input bit mid_start);
    int cyc;
    int lat;
    lat = ref_latency(f, a, b);
    check({tag, " idle_busy"}, {63'd0, busy}, 64'd0);
    start = 1'b1; funct3 = f; op_a = a; op_b = b;
    @(negedge clk);
    cyc = 1;
    start = 1'b0; funct3 = 3'($urandom); op_a = $urandom; op_b = $urandom;
    while (done !== 1'b1 && cyc < XLEN + 8) begin
      check({tag, " calc_busy"}, {63'd0, busy}, 64'd1);
      check({tag, " held_result"}, {32'd0, result}, {32'd0, last_res});
      if (mid_start && cyc == 5) begin
        start = 1'b1; funct3 = 3'($urandom); op_a = $urandom; op_b = $urandom;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check({tag, " latency"}, 64'(cyc), 64'(lat));
    check({tag, " done"}, {63'd0, done}, 64'd1);
    check({tag, " done_busy"}, {63'd0, busy}, 64'd1);
    check({tag, " result"}, {32'd0, result}, {32'd0, exp});
    last_res = exp;
    @(negedge clk);
    check({tag, " pulse_end"}, {63'd0, done}, 64'd0);
    check({tag, " back_idle"}, {63'd0, busy}, 64'd0);
  endtask

  initial begin
    logic [2:0]  f;
    logic [31:0] a, b;

    // Reset state
    #1 rst = 1'b1;
    #6;
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_result", {32'd0, result}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed vectors (spec constants)
    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul_7xm3", 1'b0);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu_m1", 1'b0);
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, "mulh_m1", 1'b0);
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_m1", 1'b0);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, "div_m7_2", 1'b0);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, "rem_m7_2", 1'b0);
    run_op(3'd5, 32'd100, 32'd7, 32'd14, "divu_100_7", 1'b0);
    run_op(3'd7, 32'd100, 32'd7, 32'd2, "remu_100_7", 1'b0);
    run_op(3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, "divu_by0", 1'b0);
    run_op(3'd7, 32'd5, 32'd0, 32'd5, "remu_by0", 1'b0);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_ovf", 1'b0);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, "rem_ovf", 1'b0);
    run_op(3'd0, 32'd1234, 32'd5678, 32'd7006652, "mul_midstart", 1'b1);

    // Flush in cycle 10 of a MUL
    start = 1'b1; funct3 = 3'd0; op_a = 32'd3; op_b = 32'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", {63'd0, busy}, 64'd0);
    check("flush_result", {32'd0, result}, {32'd0, last_res});
    for (int i = 0; i < 40; i++) begin
      check("flush_no_done", {63'd0, done}, 64'd0);
      @(negedge clk);
    end
    check("flush_result_kept", {32'd0, result}, {32'd0, last_res});

    // Flush wins over start in IDLE
    start = 1'b1; flush = 1'b1; funct3 = 3'd5; op_a = 32'd8; op_b = 32'd0;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("flush_vs_start_busy", {63'd0, busy}, 64'd0);
    check("flush_vs_start_done", {63'd0, done}, 64'd0);

    // Asynchronous reset between edges in the middle of a DIV
    start = 1'b1; funct3 = 3'd4; op_a = 32'd1000; op_b = 32'hFFFF_FFFD;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", {63'd0, busy}, 64'd0);
    check("arst_done", {63'd0, done}, 64'd0);
    check("arst_result", {32'd0, result}, 64'd0);
    rst = 1'b0;
    last_res = 32'd0;
    @(negedge clk);
    for (int i = 0; i < 40; i++) begin
      check("arst_no_done", {63'd0, done}, 64'd0);
      @(negedge clk);
    end
    run_op(3'd5, 32'd9, 32'd3, 32'd3, "divu_9_3", 1'b0);

    // Randomized ops against the reference model, back to back
    for (int i = 0; i < 48; i++) begin
      f = 3'($urandom_range(0, 7));
      a = pick_operand();
      b = pick_operand();
      run_op(f, a, b, ref_model(f, a, b), $sformatf("rnd%0d_f%0d", i, f), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, giving the operand/result width (even, >= 8).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-004 The block SHALL have port start, input, 1, request to begin an operation.
REQ-005 The block SHALL have port funct3, input, 3, RV M-extension op: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-006 The block SHALL have ports op_a and op_b, input, XLEN each, rs1 and rs2 operand values.
REQ-007 The block SHALL have port flush, input, 1, synchronous abort of any operation in progress.
REQ-008 The block SHALL have port busy, output, 1, high whenever state is not IDLE (the pipeline stall request).
REQ-009 The block SHALL have port done, output, 1, single-cycle pulse marking result valid.
REQ-010 The block SHALL have port result, output, XLEN, the operation result.

Function
REQ-011 The block SHALL implement states IDLE, CALC, DONE.
REQ-012 In IDLE, start=1 and flush=0 at a rising edge SHALL latch funct3, op_a and op_b, and the block SHALL go to CALC, or to DONE on the fast path.
REQ-013 start SHALL be ignored outside IDLE; latched operands SHALL NOT change until the block returns to IDLE.
REQ-014 CALC SHALL run a radix-2 iterative algorithm, one bit per cycle, for exactly XLEN cycles, then go to DONE; multiply is shift-add, divide is restoring.
REQ-015 Operands SHALL be converted to magnitudes per signedness: MUL/MULH/DIV/REM both signed, MULHSU op_a signed and op_b unsigned, MULHU/DIVU/REMU unsigned; the final result SHALL be negated per sign rules.
REQ-016 MUL SHALL return the low XLEN bits of the 2*XLEN product; MULH, MULHSU and MULHU SHALL return the high XLEN bits.
REQ-017 Quotients SHALL truncate toward zero; the remainder sign SHALL equal the dividend sign.
REQ-018 Fast path, divide by zero: DIV/DIVU SHALL return all ones and REM/REMU SHALL return op_a, going IDLE->DONE directly.
REQ-019 Fast path, signed overflow (DIV/REM with op_a = 1 followed by zeros and op_b = all ones): DIV SHALL return op_a and REM SHALL return 0, going IDLE->DONE directly.
REQ-020 Latency: with the start cycle as cycle 0, done SHALL be high in cycle XLEN+1 on the normal path and in cycle 1 on the fast path.
REQ-021 DONE SHALL last exactly one cycle with done=1, then return to IDLE; a new start SHALL be accepted in the IDLE cycle that follows, giving back-to-back throughput of one op per XLEN+2 cycles.
REQ-022 result SHALL update only on entry to DONE and SHALL hold its value until the next DONE.
REQ-023 flush=1 at a rising edge in CALC or DONE SHALL force IDLE with no done pulse and result unchanged; flush SHALL win over a simultaneous start in IDLE.
REQ-024 The iteration counter SHALL be ceil(log2(XLEN))+1 bits wide and SHALL NOT wrap within an operation.

Reset
REQ-025 With rst=1, state SHALL be IDLE, busy=0, done=0, result=0, and counter and internal registers SHALL be 0, asynchronously and regardless of clk.
REQ-026 rst asserted mid-operation SHALL abandon the operation; no done SHALL follow deassertion.

Verification
REQ-027 MUL op_a=7, op_b=0xFFFFFFFD -> result 0xFFFFFFEB, done in cycle 33, busy high in cycles 1-33.
REQ-028 MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000; MULHSU same operands -> 0xFFFFFFFF.
REQ-029 DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
REQ-030 DIVU 5/0 -> 0xFFFFFFFF in cycle 1; REMU 5/0 -> 5; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 in cycle 1; REM same operands -> 0.
REQ-031 flush in cycle 10 of a MUL -> busy=0 from cycle 11, no done, result keeps its prior value; start re-asserted during busy -> ignored.
REQ-032 rst pulsed between clock edges mid-DIV -> busy=0, done=0, result=0 immediately; the next DIVU 9/3 -> 3 with normal latency.
